// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and constants for the button-event CSR poster.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POST  = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_e;

    localparam int NUM_BTN = 5;

    localparam logic [2:0] BS_NONE  = 3'd0;
    localparam logic [2:0] BS_UP    = 3'd1;
    localparam logic [2:0] BS_DOWN  = 3'd2;
    localparam logic [2:0] BS_LEFT  = 3'd3;
    localparam logic [2:0] BS_RIGHT = 3'd4;
    localparam logic [2:0] BS_RESET = 3'd5;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_MID   = 4;

    localparam logic [11:0] CSR_BS   = 12'h000;
    localparam logic [11:0] CSR_MIPD = 12'h100;

    // Highest-priority press among coincident edges: mid > up > down > left > right.
    function automatic logic [2:0] btn_code(input logic [NUM_BTN-1:0] rises);
        logic [2:0] code;
        code = BS_NONE;
        if (rises[BTN_MID])        code = BS_RESET;
        else if (rises[BTN_UP])    code = BS_UP;
        else if (rises[BTN_DOWN])  code = BS_DOWN;
        else if (rises[BTN_LEFT])  code = BS_LEFT;
        else if (rises[BTN_RIGHT]) code = BS_RIGHT;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One-bit 2-FF synchroniser followed by a stable-level debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only survives while the synchronised input keeps disagreeing.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/btn_event_poster.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_poster
// Description : Debounces five buttons, posts one press code to CSR bs, raises
//               irq and clears bs/mipd once the handler acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_poster
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int DROP_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        btn_raw,
    input  logic [31:0]       mipd_dout,
    output logic [31:0]       bs_din,
    output logic              bs_we,
    output logic [31:0]       mipd_din,
    output logic              mipd_we,
    output logic              irq,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [NUM_BTN-1:0] stable_w;
    logic [NUM_BTN-1:0] stable_prev_q;
    logic [NUM_BTN-1:0] rise_w;
    logic [2:0]         new_code_w;
    logic               consume_w;
    logic               drop_evt_w;

    logic               pend_valid_q;
    logic               pend_valid_d;
    logic [2:0]         pend_code_q;
    logic [2:0]         pend_code_d;
    logic [DROP_W-1:0]  drop_q;
    logic [DROP_W-1:0]  drop_d;
    state_e             state_q;
    state_e             state_d;
    logic [2:0]         code_q;
    logic [2:0]         code_d;

    logic               unused_mipd;
    assign unused_mipd = ^mipd_dout[31:1];

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (btn_raw[gi]),
            .stable_o (stable_w[gi])
        );
    end

    assign rise_w     = stable_w & ~stable_prev_q;
    assign new_code_w = btn_code(rise_w);
    assign consume_w  = (state_q == IDLE) && pend_valid_q;

    // Pending slot: a consumed slot counts as free in the same cycle.
    always_comb begin
        pend_valid_d = pend_valid_q & ~consume_w;
        pend_code_d  = pend_code_q;
        drop_evt_w   = 1'b0;
        if (rise_w != '0) begin
            if (!pend_valid_q || consume_w) begin
                pend_valid_d = 1'b1;
                pend_code_d  = new_code_w;
                drop_evt_w   = ($countones(rise_w) > 1);
            end else if (rise_w[BTN_MID] && (pend_code_q != BS_RESET)) begin
                pend_code_d  = BS_RESET;
                drop_evt_w   = 1'b1;
            end else begin
                drop_evt_w   = 1'b1;
            end
        end
        drop_d = drop_q;
        if (drop_evt_w && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    state_d = POST;
                    code_d  = pend_code_q;
                end
            end
            POST:    state_d = WAIT;
            WAIT:    if (mipd_dout[0]) state_d = CLEAR;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev_q <= '0;
            pend_valid_q  <= 1'b0;
            pend_code_q   <= BS_NONE;
            drop_q        <= '0;
            state_q       <= IDLE;
            code_q        <= BS_NONE;
        end else begin
            stable_prev_q <= stable_w;
            pend_valid_q  <= pend_valid_d;
            pend_code_q   <= pend_code_d;
            drop_q        <= drop_d;
            state_q       <= state_d;
            code_q        <= code_d;
        end
    end

    // Outputs depend only on registered state so the CSR strobes are glitch-free.
    always_comb begin
        bs_we    = 1'b0;
        bs_din   = 32'd0;
        mipd_we  = 1'b0;
        mipd_din = 32'd0;
        irq      = 1'b0;
        case (state_q)
            POST: begin
                bs_we   = 1'b1;
                bs_din  = {29'd0, code_q};
                mipd_we = 1'b1;
                irq     = 1'b1;
            end
            WAIT: irq = 1'b1;
            CLEAR: begin
                bs_we   = 1'b1;
                mipd_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_poster.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_poster
// Description : Self-checking bench with a behavioural model of btn_event_poster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_poster;

    localparam int DEB    = 4;
    localparam int DROP_W = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0]        btn_raw = '0;
    logic [31:0]       mipd_dout = '0;
    logic [31:0]       bs_din;
    logic              bs_we;
    logic [31:0]       mipd_din;
    logic              mipd_we;
    logic              irq;
    logic              busy;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_event_poster #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (20),
        .DROP_W          (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .mipd_dout (mipd_dout),
        .bs_din    (bs_din),
        .bs_we     (bs_we),
        .mipd_din  (mipd_din),
        .mipd_we   (mipd_we),
        .irq       (irq),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0..3 = idle, posting, waiting for ack, clearing.
    int          PRIO [5] = '{4, 0, 1, 2, 3};
    int          CODE [5] = '{5, 1, 2, 3, 4};
    bit [4:0]    m_h1, m_h2, m_stable, m_prev;
    int          m_run [5];
    bit          m_pv;
    int          m_pc, m_phase, m_code, m_drop;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin : model
        bit [4:0] rises;
        int       win;
        int       nr;
        bit       dropped;
        if (rst) begin
            m_h1 = '0; m_h2 = '0; m_stable = '0; m_prev = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_pv = 1'b0; m_pc = 0; m_phase = 0; m_code = 0; m_drop = 0;
            m_ok = 1'b1;
        end else begin
            rises = m_stable & ~m_prev;
            case (m_phase)
                0: if (m_pv) begin m_phase = 1; m_code = m_pc; m_pv = 1'b0; end
                1: m_phase = 2;
                2: if (mipd_dout[0]) m_phase = 3;
                default: m_phase = 0;
            endcase
            win = 0;
            nr  = 0;
            for (int k = 0; k < 5; k++) begin
                if (rises[PRIO[k]]) begin
                    nr++;
                    if (win == 0) win = CODE[k];
                end
            end
            if (nr > 0) begin
                if (!m_pv) begin
                    m_pv = 1'b1; m_pc = win; dropped = (nr > 1);
                end else if (rises[4] && m_pc != 5) begin
                    m_pc = 5; dropped = 1'b1;
                end else begin
                    dropped = 1'b1;
                end
                if (dropped && m_drop < DROP_MAX) m_drop++;
            end
            m_prev = m_stable;
            for (int i = 0; i < 5; i++) begin
                if (m_h2[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = ~m_stable[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = btn_raw;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("bs_we",    bs_we,    (m_phase == 1 || m_phase == 3));
            check("bs_din",   bs_din,   (m_phase == 1) ? m_code : 0);
            check("mipd_we",  mipd_we,  (m_phase == 1 || m_phase == 3));
            check("mipd_din", mipd_din, 0);
            check("irq",      irq,      (m_phase == 1 || m_phase == 2));
            check("busy",     busy,     (m_phase != 0));
            check("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_raw = '0;
        mipd_dout = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_post(input string tag, input int code, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (bs_we && irq) seen = 1'b1;
        end
        check({tag, "_post_seen"}, seen, 1);
        if (seen) check({tag, "_post_code"}, bs_din, code);
    endtask

    task automatic ack(input string tag, input int budget);
        bit seen = 1'b0;
        mipd_dout = 32'h1;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (bs_we && !irq) seen = 1'b1;
        end
        mipd_dout = 32'h0;
        check({tag, "_clear_seen"}, seen, 1);
        if (seen) check({tag, "_clear_din"}, bs_din, 0);
    endtask

    task automatic count_posts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bs_we && irq) cnt++;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int cnt;
        int hold;

        // 1: reset values, single press held, ack handshake
        do_reset();
        check("rst_bs_din", bs_din, 0);
        check("rst_bs_we", bs_we, 0);
        check("rst_mipd_we", mipd_we, 0);
        check("rst_irq", irq, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        btn_raw = 5'b00001;
        wait_post("up", 1, 40);
        count_posts(20, cnt);
        check("up_single_post", cnt, 0);
        check("up_irq_held", irq, 1);
        ack("up", 10);
        check("up_irq_after_clear", irq, 0);
        btn_raw = '0;
        tick(12);

        // 2: bouncing left, then short glitches only
        do_reset();
        btn_raw[2] = 1'b1; tick(2);
        btn_raw[2] = 1'b0; tick(2);
        btn_raw[2] = 1'b1;
        wait_post("left", 3, 40);
        ack("left", 10);
        btn_raw = '0;
        tick(12);
        cnt = 0;
        for (int r = 0; r < 3; r++) begin
            int c2;
            btn_raw[2] = 1'b1; count_posts(3, c2); cnt += c2;
            btn_raw[2] = 1'b0; count_posts(8, c2); cnt += c2;
        end
        check("glitch_no_post", cnt, 0);

        // 3: down and right coincide
        do_reset();
        btn_raw = 5'b01010;
        wait_post("coincide", 2, 40);
        check("coincide_drop", drop_cnt, 1);
        ack("coincide", 10);
        btn_raw = '0;
        tick(12);

        // 4: pending left, up discarded, mid overwrites; back-to-back post
        do_reset();
        btn_raw[3] = 1'b1;
        wait_post("right", 4, 40);
        btn_raw[2] = 1'b1; tick(12);
        btn_raw[0] = 1'b1; tick(12);
        btn_raw[4] = 1'b1; tick(12);
        check("ovr_drop", drop_cnt, 2);
        check("ovr_busy", busy, 1);
        ack("ovr", 10);
        cnt = 0;
        hold = 0;
        for (int n = 1; n <= 10 && hold == 0; n++) begin
            @(negedge clk);
            if (bs_we && irq) begin
                hold = n;
                check("mid_post_code", bs_din, 5);
            end
        end
        check("b2b_gap", hold, 2);
        btn_raw = '0;
        ack("mid", 10);
        tick(12);

        // 5: reset in WAIT with up held
        do_reset();
        btn_raw[0] = 1'b1;
        wait_post("pre_rst", 1, 40);
        tick(1);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("midrst_irq", irq, 0);
        check("midrst_bs_we", bs_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop_cnt, 0);
        wait_post("post_rst", 1, 40);
        ack("post_rst", 10);
        btn_raw = '0;
        tick(12);

        // 6: saturate the drop counter
        do_reset();
        btn_raw[3] = 1'b1;
        wait_post("sat", 4, 40);
        btn_raw[2] = 1'b1; tick(12);
        for (int r = 0; r < 300; r++) begin
            btn_raw[0] = 1'b1; tick(6);
            btn_raw[0] = 1'b0; tick(6);
        end
        tick(10);
        check("drop_saturated", drop_cnt, DROP_MAX);
        btn_raw = '0;
        ack("sat", 10);
        tick(20);

        // randomized traffic against the model
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                btn_raw = 5'($urandom);
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            mipd_dout = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & ~32'h1);
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        btn_raw = '0;
        mipd_dout = '0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
